// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: lets two requesters share one external combinational ALU.
// Requests are granted round-robin. The ALU inputs are held for ALU_LAT cycles,
// then the result is captured and returned with the id of the requester that
// was served. Only one request is in flight at a time.
module alu_rr_arbiter #(
  parameter int W       = 4,
  parameter int OPW     = 4,
  parameter int ALU_LAT = 1   // legal range 1..15
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [OPW-1:0] req0_op,
  input  logic [W-1:0]   req0_a,
  input  logic [W-1:0]   req0_b,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [OPW-1:0] req1_op,
  input  logic [W-1:0]   req1_a,
  input  logic [W-1:0]   req1_b,
  output logic [OPW-1:0] alu_op,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  input  logic [W-1:0]   alu_res,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [W-1:0]   rsp_res,
  output logic           rsp_id
);

  localparam int CW = 4;
  localparam logic [CW-1:0] CNT_LOAD = CW'(ALU_LAT - 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t        state, state_nxt;
  logic          prio;      // requester that wins when both are valid
  logic [CW-1:0] cnt;       // remaining hold cycles before res is sampled
  logic          gnt_any;
  logic          gnt_id;
  logic          accept;

  // Grant selection: a lone requester always wins, a tie goes to prio.
  always_comb begin
    gnt_any = req0_valid | req1_valid;
    gnt_id  = (req0_valid && req1_valid) ? prio : req1_valid;
  end

  // A grant in IDLE is an accept, because grant already implies valid.
  assign accept = (state == IDLE) && gnt_any;

  // State register.
  // NOTE: every clocked process uses non-blocking (<=) assignments so all
  // registers update from the same pre-edge values and simulation matches
  // the synthesized flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  // NOTE: the default assignment at the top keeps this block purely
  // combinational; leaving a path where state_nxt is not written would
  // infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept)         state_nxt = EXEC;
      EXEC: if (cnt == '0)      state_nxt = RESP;
      RESP: if (rsp_ready)      state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // Ready outputs: only the granted requester, only in IDLE, never in reset.
  always_comb begin
    req0_ready = rst_n && (state == IDLE) && gnt_any && !gnt_id;
    req1_ready = rst_n && (state == IDLE) && gnt_any &&  gnt_id;
  end

  // Datapath: capture the request, count the hold time, capture the result,
  // and rotate priority once the response has been taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio      <= 1'b0;
      cnt       <= '0;
      alu_op    <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      rsp_valid <= 1'b0;
      rsp_res   <= '0;
      rsp_id    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            alu_op <= gnt_id ? req1_op : req0_op;
            alu_a  <= gnt_id ? req1_a  : req0_a;
            alu_b  <= gnt_id ? req1_b  : req0_b;
            rsp_id <= gnt_id;
            cnt    <= CNT_LOAD;
          end
        end
        EXEC: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            rsp_res   <= alu_res;
            rsp_valid <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            prio      <= ~rsp_id;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
